serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a-b LSB-first over WIDTH cycles.
// diff/borrow are valid and held from the done pulse until the next accepted start.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, a_next;
  logic [WIDTH-1:0] b_sh, b_next;
  logic [WIDTH-1:0] diff_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             br, br_next;
  logic             borrow_next, busy_next, done_next;
  logic             d_bit, bout;

  // Full subtractor on the current LSBs.
  assign d_bit = a_sh[0] ^ b_sh[0] ^ br;
  assign bout  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      a_sh   <= a_next;
      b_sh   <= b_next;
      cnt    <= cnt_next;
      br     <= br_next;
      diff   <= diff_next;
      borrow <= borrow_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    a_next      = a_sh;
    b_next      = b_sh;
    cnt_next    = cnt;
    br_next     = br;
    diff_next   = diff;
    borrow_next = borrow;
    case (state)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          br_next    = 1'b0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        diff_next = {d_bit, diff[WIDTH-1:1]};
        a_next    = a_sh >> 1;
        b_next    = b_sh >> 1;
        br_next   = bout;
        // Counter holds on the final bit so it never wraps.
        if (cnt == CW'(WIDTH - 1)) begin
          borrow_next = bout;
          state_next  = DONE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed scenarios plus
// randomized operands compared against plain integer subtraction.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, diff;
  logic         borrow, busy, done;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .diff(diff), .borrow(borrow), .busy(busy), .done(done)
  );

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r = r + (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  // Issues one start pulse and waits (bounded) for done; lat counts cycles after the accepting edge.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] rd, output logic rb, output int lat,
                        output logic busy0, output logic done_after, output logic busy_after);
    @(negedge clk); a = ia; b = ib; start = 1'b1;
    @(negedge clk); busy0 = busy; start = 1'b0;
    lat = -1; rd = '0; rb = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin lat = n; rd = diff; rb = borrow; break; end
    end
    @(negedge clk); done_after = done; busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'h5A; b = 8'h33;
    repeat (2) @(negedge clk);
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h exp 00", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", borrow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] rd; logic rb, b0, da, ba; int lat;
    run_op(8'h35, 8'h12, rd, rb, lat, b0, da, ba);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", b0); end
    checks++; if (lat != int'(W)) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, W); end
    checks++; if (rd !== 8'h23) begin errors++; $display("FAIL basic_diff got %h exp 23", rd); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b exp 0", rb); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", da); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", ba); end
    // Result must hold in IDLE while the operand inputs wander.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    checks++; if (diff !== 8'h23 || borrow !== 1'b0) begin
      errors++; $display("FAIL basic_hold got %h/%b exp 23/0", diff, borrow);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] rd; logic rb, b0, da, ba; int lat;
    run_op(8'h00, 8'h01, rd, rb, lat, b0, da, ba);
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL underflow_diff got %h exp ff", rd); end
    checks++; if (rb !== 1'b1) begin errors++; $display("FAIL underflow_borrow got %b exp 1", rb); end
    run_op(8'hAA, 8'hAA, rd, rb, lat, b0, da, ba);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL equal_diff got %h exp 00", rd); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL equal_borrow got %b exp 0", rb); end
  endtask

  task automatic test_ignore_start();
    int pulses = 0; logic [W-1:0] rd = '0; logic rb = 1'b1;
    @(negedge clk); a = 8'h80; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done) begin pulses++; rd = diff; rb = borrow; end
      if (cyc == 2) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (cyc == 3) start = 1'b0;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
    checks++; if (rd !== 8'h7F) begin errors++; $display("FAIL ignore_diff got %h exp 7f", rd); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL ignore_borrow got %b exp 0", rb); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rd; logic rb, b0, da, ba; int lat; int pulses = 0; int busy_seen = 0;
    run_op(8'h00, 8'h01, rd, rb, lat, b0, da, ba);
    checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL pre_reset_borrow got %b exp 1", borrow); end
    @(negedge clk); a = 8'h35; b = 8'h12; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (diff !== 8'h00 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got %h/%b/%b/%b exp 00/0/0/0", diff, borrow, busy, done);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", pulses); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL midreset_idle got %0d exp 0", busy_seen); end
    // A start in the first cycle after reset release must be taken.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_accept got %b exp 1", busy); end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin lat = n; rd = diff; rb = borrow; break; end
    end
    checks++; if (lat != int'(W) || rd !== 8'hF0 || rb !== 1'b1) begin
      errors++; $display("FAIL post_reset_result got lat=%0d %h/%b exp lat=%0d f0/1", lat, rd, rb, W);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0; int prev = 0;
    @(negedge clk); a = 8'hFF; b = 8'h0F; start = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        checks++; if (diff !== 8'hF0 || borrow !== 1'b0) begin
          errors++; $display("FAIL b2b_result got %h/%b exp f0/0", diff, borrow);
        end
        if (pulses > 1) begin
          checks++; if (cyc - prev != int'(W) + 2) begin
            errors++; $display("FAIL b2b_period got %0d exp %0d", cyc - prev, W + 2);
          end
        end
        prev = cyc;
      end
    end
    start = 1'b0;
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses got %0d exp 4", pulses); end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rbv, rd; logic rb, b0, da, ba; int lat; int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rbv = 8'($urandom);
      if (i % 50 == 0) rbv = ra;
      run_op(ra, rbv, rd, rb, lat, b0, da, ba);
      checks++;
      if (rd !== ref_diff(ra, rbv) || rb !== ref_borrow(ra, rbv) || lat != int'(W)) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL random a=%h b=%h got %h/%b lat=%0d exp %h/%b lat=%0d",
                   ra, rbv, rd, rb, lat, ref_diff(ra, rbv), ref_borrow(ra, rbv), W);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_edges();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
